// File: rtl/inv_mix_columns_iter_if.sv
// inv_mix_columns_iter_if: handshake bundle for the iterative InvMixColumns engine
// in_valid/in_ready/in_state : input state channel (producer -> engine)
// out_valid/out_ready/out_state : result channel (engine -> consumer)
// fwd : forward-matrix select, present only with MIXCOL_FWD_EN
// master = producer/consumer side, slave = engine side
interface inv_mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef MIXCOL_FWD_EN
    logic         fwd;
    modport master (output in_valid, in_state, out_ready, fwd, input in_ready, out_valid, out_state);
    modport slave (input in_valid, in_state, out_ready, fwd, output in_ready, out_valid, out_state);
`else
    modport master (output in_valid, in_state, out_ready, input in_ready, out_valid, out_state);
    modport slave (input in_valid, in_state, out_ready, output in_ready, out_valid, out_state);
`endif
endinterface

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, one column per clock
// clk, rst : single clock, synchronous active-high reset
// bus      : inv_mix_columns_iter_if.slave (in/out valid-ready channels, 128-bit states)
// byte(r,c) lives at bits [127-8*(4r+c) -: 8]
// MIXCOL_FWD_EN : adds bus.fwd, sampled at accept, selecting the forward matrix
module inv_mix_columns_iter (
    input logic clk,
    input logic rst,
    inv_mix_columns_iter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]   st;
    logic [1:0]   col;
    logic [127:0] work;
    logic [127:0] res;
    logic [7:0]   s[4];
    logic [7:0]   x2[4];
    logic [7:0]   x4[4];
    logic [7:0]   x8[4];
    logic [7:0]   o[4];
    logic         accept;
`ifdef MIXCOL_FWD_EN
    logic         fwd_q;
`endif
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    assign bus.in_ready  = (st == IDLE) | ((st == DONE) & bus.out_ready);
    assign bus.out_valid = st == DONE;
    assign bus.out_state = res;
    assign accept        = bus.in_valid & bus.in_ready;
    for (genvar i = 0; i < 4; i++) begin : g_mul
        assign s[i]  = work[127 - 32*i - 8*col -: 8];
        assign x2[i] = xt(s[i]);
        assign x4[i] = xt(x2[i]);
        assign x8[i] = xt(x4[i]);
    end
    // row i sees the column rotated by i: coefficient k applies to s[(i+k)%4]
    for (genvar i = 0; i < 4; i++) begin : g_row
        logic [7:0] inv_b;
        assign inv_b = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
`ifdef MIXCOL_FWD_EN
        logic [7:0] fwd_b;
        assign fwd_b = x2[i] ^ x2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
        assign o[i]  = fwd_q ? fwd_b : inv_b;
`else
        assign o[i]  = inv_b;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            col  <= 2'd0;
            work <= 128'h0;
            res  <= 128'h0;
`ifdef MIXCOL_FWD_EN
            fwd_q <= 1'b0;
`endif
        end else if (accept) begin
            st   <= BUSY;
            col  <= 2'd0;
            work <= bus.in_state;
`ifdef MIXCOL_FWD_EN
            fwd_q <= bus.fwd;
`endif
        end else if (st == BUSY) begin
            for (int r = 0; r < 4; r++) res[127 - 32*r - 8*col -: 8] <= o[r];
            col <= col + 2'd1;
            st  <= (col == 2'd3) ? DONE : BUSY;
        end else if (st == DONE && bus.out_ready) begin
            st <= IDLE;
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: randomized + directed self-checking bench with a GF(2^8) reference model
module tb_inv_mix_columns_iter;
    localparam logic [127:0] KV   = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
    localparam logic [127:0] KE   = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
    localparam logic [127:0] ONES = 128'h01010101_01010101_01010101_01010101;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [127:0] eq[$];
    int et[$];
    logic mf;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    inv_mix_columns_iter_if bus ();
    inv_mix_columns_iter dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef MIXCOL_FWD_EN
    assign mf = bus.fwd;
`else
    assign mf = 1'b0;
`endif
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [127:0] model(input logic [127:0] x, input logic f);
        logic [7:0] m[4];
        logic [7:0] acc;
        logic [127:0] y = 128'h0;
        if (f) begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end else begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(m[k], x[127 - 8*(4*((r+k)%4) + c) -: 8]);
                y[127 - 8*(4*r + c) -: 8] = acc;
            end
        return y;
    endfunction
    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask
    // per-cycle compare: at most one state in flight, result due 4 edges after its accept edge
    always @(negedge clk) begin
        logic ev;
        if (rst) begin
            eq.delete();
            et.delete();
        end else begin
            ev = eq.size() > 0 && cyc >= et[0] + 4;
            chk("out_valid", {127'h0, bus.out_valid}, {127'h0, ev});
            chk("in_ready", {127'h0, bus.in_ready}, {127'h0, eq.size() == 0 || (ev && bus.out_ready)});
            if (bus.out_valid && ev) begin
                chk("out_state", bus.out_state, eq[0]);
                if (bus.out_ready) begin
                    void'(eq.pop_front());
                    void'(et.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                eq.push_back(model(bus.in_state, mf));
                et.push_back(cyc + 1);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_fwd(input logic f);
`ifdef MIXCOL_FWD_EN
        bus.fwd = f;
`else
        if (f) $display("fwd requested without MIXCOL_FWD_EN");
`endif
    endtask
    task automatic send(input logic [127:0] x, input logic f, output int t);
        int n = 0;
        bus.in_state = x;
        bus.in_valid = 1'b1;
        set_fwd(f);
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("accept_timeout", 128'h0, 128'h1);
        tick();
        t = cyc;
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_out(output int t);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("out_timeout", 128'h0, 128'h1);
        t = cyc;
    endtask
    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    initial begin
        int ta, tv, tp;
        logic [127:0] r1, r2, held, y;
        bus.in_valid = 1'b0;
        bus.in_state = 128'h0;
        bus.out_ready = 1'b1;
        set_fwd(1'b0);
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
        chk("rst_in_ready", {127'h0, bus.in_ready}, 128'h1);
        chk("rst_out_state", bus.out_state, 128'h0);
        chk("model_kv", model(KV, 1'b0), KE);
        chk("model_ones", model(ONES, 1'b0), ONES);
        chk("model_zero", model(128'h0, 1'b0), 128'h0);
        chk("model_fwd", model(KE, 1'b1), KV);
        send(KV, 1'b0, ta);
        wait_out(tv);
        chk("latency", 128'(tv - ta), 128'd4);
        chk("kv", bus.out_state, KE);
        tick();
        send(128'h0, 1'b0, ta);
        wait_out(tv);
        chk("zero", bus.out_state, 128'h0);
        tick();
        send(ONES, 1'b0, ta);
        wait_out(tv);
        chk("ones", bus.out_state, ONES);
        tick();
        r1 = rnd();
        r2 = rnd();
        bus.out_ready = 1'b0;
        send(r1, 1'b0, ta);
        wait_out(tv);
        held = bus.out_state;
        bus.in_valid = 1'b1;
        bus.in_state = r2;
        repeat (10) begin
            tick();
            chk("bp_in_ready", {127'h0, bus.in_ready}, 128'h0);
        end
        chk("bp_hold", bus.out_state, held);
        chk("bp_result", held, model(r1, 1'b0));
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {127'h0, bus.in_ready}, 128'h1);
        tick();
        bus.in_valid = 1'b0;
        wait_out(tv);
        chk("bp_next", bus.out_state, model(r2, 1'b0));
        tick();
        tp = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            bus.in_state = rnd();
            while (!bus.in_ready && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) chk("stream_timeout", 128'h0, 128'h1);
            tick();
            if (i > 0) chk("stream_period", 128'(cyc - tp), 128'd5);
            tp = cyc;
        end
        bus.in_valid = 1'b0;
        wait_out(tv);
        tick();
        send(rnd(), 1'b0, ta);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", {127'h0, bus.in_ready}, 128'h1);
        chk("mid_rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
        r1 = rnd();
        send(r1, 1'b0, ta);
        wait_out(tv);
        chk("post_rst", bus.out_state, model(r1, 1'b0));
        tick();
`ifdef MIXCOL_FWD_EN
        send(KE, 1'b1, ta);
        wait_out(tv);
        chk("fwd_kv", bus.out_state, KV);
        tick();
        r1 = rnd();
        send(r1, 1'b1, ta);
        wait_out(tv);
        y = bus.out_state;
        tick();
        send(y, 1'b0, ta);
        wait_out(tv);
        chk("fwd_roundtrip", bus.out_state, r1);
        tick();
`else
        y = 128'h0;
`endif
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_state = rnd();
            bus.out_ready = 1'($urandom_range(0, 1));
            set_fwd(1'($urandom_range(0, 1)) & mf_ok());
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    function automatic logic mf_ok();
`ifdef MIXCOL_FWD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction
endmodule
